// File: rtl/ntt_out_serializer_pkg.sv
// Shared sizing, FSM encoding and index helpers for the NTT output serializer.
// Sizes come from DATA_SIZE_ARB / RING_DEPTH / PE_DEPTH when defined.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif
`ifndef RING_DEPTH
`define RING_DEPTH 5
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 1
`endif

package ntt_out_serializer_pkg;
  localparam int DATA_W     = `DATA_SIZE_ARB;
  localparam int RING_DEPTH = `RING_DEPTH;
  localparam int PE_DEPTH   = `PE_DEPTH;
  localparam int WW   = PE_DEPTH + 1;
  localparam int RW   = RING_DEPTH - PE_DEPTH - 1;
  localparam int WPR  = 2 ** WW;
  localparam int ROWS = 2 ** RW;
  localparam int N    = 2 ** RING_DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  function automatic logic [RING_DEPTH-1:0] bitrev(
    input logic [RING_DEPTH-1:0] v
  );
    logic [RING_DEPTH-1:0] r;
    for (int b = 0; b < RING_DEPTH; b++)
      r[b] = v[RING_DEPTH-1-b];
    return r;
  endfunction
endpackage

// File: rtl/ntt_out_serializer_if.sv
// Core-side row input plus serialized valid/ready output stream.
// master = serializer, slave = core/consumer side.
interface ntt_out_serializer_if;
  import ntt_out_serializer_pkg::*;

  logic                  done;
  logic [WPR*DATA_W-1:0] bram_out;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  overrun;

  modport master (
    input  done, bram_out, out_ready,
    output out_data, out_valid, out_last,
    output busy, overrun
  );

  modport slave (
    output done, bram_out, out_ready,
    input  out_data, out_valid, out_last,
    input  busy, overrun
  );
endinterface

// File: rtl/ntt_out_serializer_row.sv
// Row buffer: ROWS x (WPR*DATA_W) dual-port RAM, registered read.
// Only the read register is reset so the stream output starts at zero.
module ntt_row_buffer
  import ntt_out_serializer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [RW-1:0]         i_waddr,
  input  logic [WPR*DATA_W-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [RW-1:0]         i_raddr,
  output logic [WPR*DATA_W-1:0] o_rdata
);
  logic [WPR*DATA_W-1:0] r_mem [ROWS];
  logic [WPR*DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ntt_out_serializer.sv
// Captures an unstallable NTT output burst and replays it one word per beat.
// OUT_BITREV_EN: emit bit-reversed index order, drain after capture ends.
module ntt_out_serializer
  import ntt_out_serializer_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  ntt_out_serializer_if.master bus
);
  state_e r_state, w_next;
  logic [RW-1:0]         r_wptr;
  logic [RING_DEPTH-1:0] r_ridx;
  logic                  r_rend;
  logic                  r_valid, r_last, r_ovr;
  logic [WW-1:0]         r_sel;
  logic [WPR*DATA_W-1:0] w_rdata;
  logic [RING_DEPTH-1:0] w_idx;
  logic [RW-1:0]         w_rrow;
  logic [DATA_W-1:0]     w_word;
  logic w_we, w_re, w_adv, w_xfer;
  logic w_avail, w_start, w_wend, w_rlast;

  // Read index k maps to the buffered coefficient it names
`ifdef OUT_BITREV_EN
  assign w_idx   = bitrev(r_ridx);
  assign w_avail = !r_rend && r_state == DRAIN;
`else
  assign w_idx   = r_ridx;
  assign w_avail = !r_rend &&
    ((r_state == CAPTURE && w_rrow < r_wptr) ||
     r_state == DRAIN);
`endif

  assign w_rrow  = w_idx[RING_DEPTH-1:WW];
  assign w_xfer  = r_valid && bus.out_ready;
  assign w_adv   = !r_valid || bus.out_ready;
  assign w_re    = w_adv && w_avail;
  assign w_wend  = r_wptr == RW'(ROWS - 1);
  assign w_rlast = r_ridx == RING_DEPTH'(N - 1);

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_start = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.done) begin
          w_next  = CAPTURE;
          w_start = 1'b1;
        end
      end
      CAPTURE: begin
        w_we = 1'b1;
        if (w_wend) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_xfer && r_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_ridx  <= '0;
      r_rend  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_sel   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_wptr <= '0;
        r_ridx <= '0;
        r_rend <= 1'b0;
      end else begin
        if (w_we && !w_wend) r_wptr <= r_wptr + 1'b1;
        if (w_re) begin
          if (w_rlast) r_rend <= 1'b1;
          else         r_ridx <= r_ridx + 1'b1;
        end
      end
      if (w_adv) begin
        r_valid <= w_re;
        r_last  <= w_re && w_rlast;
        if (w_re) r_sel <= w_idx[WW-1:0];
      end
      if (bus.done && r_state != IDLE) r_ovr <= 1'b1;
    end
  end

  ntt_row_buffer u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (bus.bram_out),
    .i_re    (w_re),
    .i_raddr (w_rrow),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_word = '0;
    for (int n = 0; n < WPR; n++)
      if (r_sel == WW'(n))
        w_word = w_rdata[DATA_W*n +: DATA_W];
  end

  assign bus.out_data  = w_word;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.busy      = r_state != IDLE;
  assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_ntt_out_serializer.sv
// Directed + randomized bench for ntt_out_serializer against a row/queue model.
// Handles both natural and OUT_BITREV_EN output orders.
module tb_ntt_out_serializer;
  import ntt_out_serializer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   ovr_model = 1'b0;

`ifdef OUT_BITREV_EN
  localparam int LAT = ROWS + 2;
`else
  localparam int LAT = 3;
`endif

  ntt_out_serializer_if bus ();

  ntt_out_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int order(input int k);
`ifdef OUT_BITREV_EN
    int r = 0;
    for (int b = 0; b < RING_DEPTH; b++)
      if (((k >> b) & 1) != 0) r += 1 << (RING_DEPTH - 1 - b);
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [WPR*DATA_W-1:0] rnd_row();
    logic [WPR*DATA_W-1:0] v;
    for (int n = 0; n < WPR; n++)
      v[DATA_W*n +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  // rmode: 0 ready high, 1 toggling, 2 held low 100 cycles, 3 random
  // dbl: cycle offset of a second done, -2 = on final transfer
  // abort_k: assert reset once this many words were accepted
  task automatic stream(input int rmode, input bit rnd,
                        input int base, input int dbl,
                        input int abort_k);
    logic [DATA_W-1:0] rows [ROWS][WPR];
    logic [DATA_W-1:0] expq [N];
    int  k = 0;
    int  first = -1;
    bit  fin = 1'b0;
    bit  aborted = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int n = 0; n < WPR; n++)
        rows[r][n] = rnd ? DATA_W'($urandom) :
                           DATA_W'(base + WPR*r + n);
    for (int i = 0; i < N; i++) begin
      int idx = order(i);
      expq[i] = rows[idx / WPR][idx % WPR];
    end

    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_valid", bus.out_valid, 0);
    bus.done      = 1'b1;
    bus.bram_out  = rnd_row();
    bus.out_ready = (rmode == 0);

    for (int c = 1; c <= 400 && !fin && !aborted; c++) begin
      @(negedge clk);
      bus.done = (c == dbl);
      if (c == dbl) ovr_model = 1'b1;
      if (c <= ROWS)
        for (int n = 0; n < WPR; n++)
          bus.bram_out[DATA_W*n +: DATA_W] = rows[c-1][n];
      else
        bus.bram_out = rnd_row();
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (c % 2) == 1;
        2:       bus.out_ready = c > 100;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      check("busy", bus.busy, 1);
      if (rmode == 0 && first < 0 && bus.out_valid) begin
        first = c;
        check("first_valid_cycle", c, LAT);
      end
      if (rmode == 0 && first >= 0)
        check("no_gap", bus.out_valid, 1);
      if (bus.out_valid) begin
        check("data", bus.out_data, expq[k]);
        check("last", bus.out_last, k == N - 1);
        if (bus.out_ready) begin
          if (k == N - 1 && dbl == -2) begin
            bus.done  = 1'b1;
            ovr_model = 1'b1;
          end
          k++;
          if (k == N) fin = 1'b1;
          if (k == abort_k) aborted = 1'b1;
        end
      end
    end

    if (aborted) begin
      @(negedge clk);
      bus.done = 1'b0;
      reset = 1'b0;
      ovr_model = 1'b0;
      #1;
      check("abort_valid", bus.out_valid, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_last", bus.out_last, 0);
      check("abort_overrun", bus.overrun, 0);
      @(negedge clk);
      reset = 1'b1;
      return;
    end

    if (!fin) check("timeout_words", k, N);
    @(negedge clk);
    bus.done = 1'b0;
    check("end_valid", bus.out_valid, 0);
    check("end_busy", bus.busy, 0);
    check("end_last", bus.out_last, 0);
    check("overrun", bus.overrun, ovr_model);
    repeat (3) @(negedge clk);
    check("no_restart_valid", bus.out_valid, 0);
    check("no_restart_busy", bus.busy, 0);
  endtask

  initial begin
    bus.done      = 1'b0;
    bus.out_ready = 1'b0;
    bus.bram_out  = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    reset = 1'b1;

    stream(0, 1'b0, 0, -1, -1);
    stream(1, 1'b0, 0, -1, -1);
    stream(2, 1'b0, 0, -1, -1);
    stream(0, 1'b0, 0, 5, -1);
    stream(3, 1'b1, 0, -1, -1);
    stream(0, 1'b0, 0, -1, 11);
    stream(0, 1'b0, 100, -1, -1);
    stream(3, 1'b1, 0, -2, -1);
    repeat (4) stream(3, 1'b1, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
